sim_watchdog: RTL and testbench
===============================

# sim_watchdog

Cycle-level run supervisor for the simulation top level. Starts timing on a `start` pulse, watches the dut's `heartbeat` and `done`/`pass` outputs, and ends in exactly one terminal verdict: DONE (pass/fail), TIMEOUT (overall cycle budget exhausted) or HANG (no progress for too long). It sits beside `dut` in the top-level timeout section and consumes the dut's status outputs. Optionally it ends the simulation itself.

## Interface
- `MAX_CYCLES`, default 100000: overall RUN-cycle budget, must be ≥ 1
- `IDLE_LIMIT`, default 1000: consecutive RUN cycles without heartbeat before HANG; 0 disables hang detection
- `CNT_W`, default 32: counter width, must satisfy 2^CNT_W > max(MAX_CYCLES, IDLE_LIMIT)
- `FINISH_ON_END`, default 0: 1 means print the verdict and end the simulation one cycle after entering a terminal state (simulation-only, excluded under SYNTHESIS)
- `ck` in, 1: the single clock
- `rst` in, 1: asynchronous, active-high reset
- `start` in, 1: begin supervision; sampled only in IDLE
- `heartbeat` in, 1: dut progress pulse
- `done` in, 1: dut completion pulse
- `pass` in, 1: dut verdict, qualified by `done`
- `state_o` out, 3: current state encoding
- `running` out, 1: state is RUN
- `finished` out, 1: any terminal state
- `result_pass` out, 1: DONE with `pass`=1
- `cycle_count` out, CNT_W: RUN cycles elapsed
- `idle_count` out, CNT_W: consecutive RUN cycles without heartbeat

## Operation
- States: IDLE=0, RUN=1, DONE=2, TIMEOUT=3, HANG=4.
- IDLE→RUN when `start`=1. On that edge `cycle_count` and `idle_count` load 0.
- RUN, evaluated each cycle in this priority order:
  - `done`=1: go to DONE and latch `result_pass` from `pass`.
  - else if `cycle_count`==MAX_CYCLES-1: go to TIMEOUT.
  - else if IDLE_LIMIT≠0, `heartbeat`=0 and `idle_count`==IDLE_LIMIT-1: go to HANG.
  - else stay in RUN. `cycle_count` increments. `idle_count` becomes 0 if `heartbeat`=1, otherwise it increments.
- Simultaneous events: `done` beats TIMEOUT and HANG, and TIMEOUT beats HANG. A `heartbeat` in the final budget cycle does not prevent TIMEOUT.
- Terminal states are sticky until `rst`. Counters freeze on leaving RUN. `start`, `heartbeat`, `done` and `pass` are ignored outside the states where they are sampled.
- `start` in RUN is ignored; there is no restart.
- Counters saturate at all-ones and never wrap. Saturation is unreachable under the CNT_W rule above.
- `pass` is ignored when `done`=0.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- Reset values: `state_o`=0 (IDLE), `running`=0, `finished`=0, `result_pass`=0, `cycle_count`=0, `idle_count`=0.
- `start` sampled high at edge N: `running`=1 from edge N, and `cycle_count`=0 during the first RUN cycle.
- With no `done`, TIMEOUT is entered at the edge that ends RUN cycle MAX_CYCLES, and `cycle_count` holds MAX_CYCLES-1.
- `done` is honoured in every RUN cycle, including the last budget cycle.
- `rst` asserted mid-RUN or in a terminal state clears everything immediately and asynchronously. After release the block waits in IDLE for a new `start`.
- FINISH_ON_END=1: the verdict is printed and the simulation ends on the edge after terminal entry, exactly once.

## Structure
- Shared package `sim_watchdog_pkg`:
  - `wd_state_e` enum (3 bits, encodings above)
  - localparam `WD_STATE_W`=3
  - a verdict-string function used by the FINISH_ON_END print
- Sub-module `wd_sat_counter`: parameter W; ports `ck`, `rst`, `clr`, `inc`, `q`; clear has priority over increment; saturates at all-ones. Instantiated twice (cycle counter, idle counter).
- The top of this block holds the FSM, the priority logic and the verdict latch.

## Test plan
- MAX_CYCLES=20, IDLE_LIMIT=5, heartbeat every 2 cycles, `done`=1 with `pass`=1 at RUN cycle 10 → state 2, `result_pass`=1, `cycle_count`=9 (frozen).
- MAX_CYCLES=20, IDLE_LIMIT=0, no `done` → TIMEOUT after 20 RUN cycles, `cycle_count`=19, `finished`=1, `result_pass`=0.
- IDLE_LIMIT=5, heartbeat stops after RUN cycle 3 → HANG after 5 silent cycles, `idle_count`=4. A late `done` afterwards → still HANG.
- `done`, `pass`=0 and the budget limit in the same cycle → DONE with `result_pass`=0. Heartbeat together with the limit cycle and no `done` → TIMEOUT.
- `rst` pulsed mid-RUN (cycle 7) → all outputs 0 immediately. A new `start` → `cycle_count` restarts from 0. A second `start` during RUN → no effect.

Source files
------------

// File: rtl/sim_watchdog_pkg.sv
// Shared types and helpers for the simulation run supervisor.
// State encodings are fixed because the top level decodes state_o directly.
package sim_watchdog_pkg;

    localparam int WD_STATE_W = 3;

    typedef enum logic [WD_STATE_W-1:0] {
        WD_IDLE    = 3'd0,
        WD_RUN     = 3'd1,
        WD_DONE    = 3'd2,
        WD_TIMEOUT = 3'd3,
        WD_HANG    = 3'd4
    } wd_state_e;

`ifndef SYNTHESIS
    function automatic string wd_verdict_str(input logic [WD_STATE_W-1:0] state, input logic pass);
        string s;
        case (state)
            WD_DONE:    s = pass ? "DONE (pass)" : "DONE (fail)";
            WD_TIMEOUT: s = "TIMEOUT";
            WD_HANG:    s = "HANG";
            WD_RUN:     s = "RUN";
            default:    s = "IDLE";
        endcase
        return s;
    endfunction
`endif

endpackage

// File: rtl/sim_watchdog_if.sv
// Status/handshake bundle between the dut side of the top level and the watchdog.
// The master drives the dut status pulses; the slave (watchdog) reports its verdict.
interface sim_watchdog_if
    import sim_watchdog_pkg::*;
#(
    parameter int CNT_W = 32
);
    logic                  start;
    logic                  heartbeat;
    logic                  done;
    logic                  pass;
    logic [WD_STATE_W-1:0] state_o;
    logic                  running;
    logic                  finished;
    logic                  result_pass;
    logic [CNT_W-1:0]      cycle_count;
    logic [CNT_W-1:0]      idle_count;

    modport master (
        output start, heartbeat, done, pass,
        input  state_o, running, finished, result_pass, cycle_count, idle_count
    );

    modport slave (
        input  start, heartbeat, done, pass,
        output state_o, running, finished, result_pass, cycle_count, idle_count
    );
endinterface

// File: rtl/wd_sat_counter.sv
// Up-counter with synchronous clear (priority over increment) that sticks at all-ones.
module wd_sat_counter #(
    parameter int W = 32
) (
    input  logic         ck,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/sim_watchdog.sv
// Run supervisor: times a RUN phase and settles on exactly one sticky verdict
// (DONE, TIMEOUT or HANG) from the dut's done/heartbeat pulses.
module sim_watchdog
    import sim_watchdog_pkg::*;
#(
    parameter int MAX_CYCLES    = 100000,
    parameter int IDLE_LIMIT    = 1000,
    parameter int CNT_W         = 32,
    parameter int FINISH_ON_END = 0
) (
    input  logic           ck,
    input  logic           rst,
    sim_watchdog_if.slave  bus
);

    localparam logic [WD_STATE_W-1:0] ST_IDLE    = WD_IDLE;
    localparam logic [WD_STATE_W-1:0] ST_RUN     = WD_RUN;
    localparam logic [WD_STATE_W-1:0] ST_DONE    = WD_DONE;
    localparam logic [WD_STATE_W-1:0] ST_TIMEOUT = WD_TIMEOUT;
    localparam logic [WD_STATE_W-1:0] ST_HANG    = WD_HANG;

    localparam logic [CNT_W-1:0] LAST_CYCLE = CNT_W'(MAX_CYCLES - 1);
    localparam logic [CNT_W-1:0] LAST_IDLE  = CNT_W'((IDLE_LIMIT == 0) ? 0 : IDLE_LIMIT - 1);
    localparam logic             HANG_EN    = (IDLE_LIMIT != 0);

    logic [WD_STATE_W-1:0] state_q, state_next;
    logic                  running_q, finished_q, pass_q, pass_next;
    logic [CNT_W-1:0]      cycle_q, idle_q;
    logic                  cyc_clr, cyc_inc, idl_clr, idl_inc;

    // Priority inside RUN: done, then budget, then hang. Counters only move
    // while staying in RUN, so they freeze at the values seen on exit.
    always_comb begin
        state_next = state_q;
        pass_next  = pass_q;
        cyc_clr    = 1'b0;
        cyc_inc    = 1'b0;
        idl_clr    = 1'b0;
        idl_inc    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_next = ST_RUN;
                    cyc_clr    = 1'b1;
                    idl_clr    = 1'b1;
                end
            end
            ST_RUN: begin
                if (bus.done) begin
                    state_next = ST_DONE;
                    pass_next  = bus.pass;
                end else if (cycle_q == LAST_CYCLE) begin
                    state_next = ST_TIMEOUT;
                end else if (HANG_EN && !bus.heartbeat && (idle_q == LAST_IDLE)) begin
                    state_next = ST_HANG;
                end else begin
                    cyc_inc = 1'b1;
                    idl_clr = bus.heartbeat;
                    idl_inc = !bus.heartbeat;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            running_q  <= 1'b0;
            finished_q <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_next;
            running_q  <= (state_next == ST_RUN);
            finished_q <= (state_next == ST_DONE) || (state_next == ST_TIMEOUT)
                          || (state_next == ST_HANG);
            pass_q     <= pass_next;
        end
    end

    wd_sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .ck  (ck),
        .rst (rst),
        .clr (cyc_clr),
        .inc (cyc_inc),
        .q   (cycle_q)
    );

    wd_sat_counter #(.W(CNT_W)) u_idle_cnt (
        .ck  (ck),
        .rst (rst),
        .clr (idl_clr),
        .inc (idl_inc),
        .q   (idle_q)
    );

    assign bus.state_o     = state_q;
    assign bus.running     = running_q;
    assign bus.finished    = finished_q;
    assign bus.result_pass = pass_q;
    assign bus.cycle_count = cycle_q;
    assign bus.idle_count  = idle_q;

`ifndef SYNTHESIS
    generate
        if (FINISH_ON_END != 0) begin : g_finish
            logic reported;
            always @(posedge ck or posedge rst) begin
                if (rst) begin
                    reported <= 1'b0;
                end else if (finished_q && !reported) begin
                    reported <= 1'b1;
                    $display("sim_watchdog verdict: %s", wd_verdict_str(state_q, pass_q));
                    $finish;
                end
            end
        end
    endgenerate
`endif

endmodule

// File: tb/tb_sim_watchdog.sv
// Directed bench for sim_watchdog: two instances (hang detection on / off), one task per scenario.
module tb_sim_watchdog;

    logic ck = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 ck = ~ck;

    sim_watchdog_if #(.CNT_W(8)) ifa ();
    sim_watchdog_if #(.CNT_W(8)) ifb ();

    sim_watchdog #(.MAX_CYCLES(20), .IDLE_LIMIT(5), .CNT_W(8), .FINISH_ON_END(0)) dut_a (
        .ck (ck), .rst (rst), .bus (ifa)
    );

    sim_watchdog #(.MAX_CYCLES(20), .IDLE_LIMIT(0), .CNT_W(8), .FINISH_ON_END(0)) dut_b (
        .ck (ck), .rst (rst), .bus (ifb)
    );

    task automatic idle_inputs();
        ifa.start = 1'b0; ifa.heartbeat = 1'b0; ifa.done = 1'b0; ifa.pass = 1'b0;
        ifb.start = 1'b0; ifb.heartbeat = 1'b0; ifb.done = 1'b0; ifb.pass = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge ck);
        rst = 1'b1;
        idle_inputs();
        @(negedge ck);
        rst = 1'b0;
    endtask

    // Leaves the bench at the negedge inside RUN cycle 1.
    task automatic start_a();
        @(negedge ck) ifa.start = 1'b1;
        @(negedge ck) ifa.start = 1'b0;
    endtask

    task automatic start_b();
        @(negedge ck) ifb.start = 1'b1;
        @(negedge ck) ifb.start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        #12;
        checks++;
        if ({ifa.state_o, ifa.running, ifa.finished, ifa.result_pass, ifa.cycle_count, ifa.idle_count} !== 22'd0) begin
            errors++;
            $display("FAIL reset_a: got state=%0d run=%b fin=%b pass=%b cyc=%0d idle=%0d, expected all zero",
                     ifa.state_o, ifa.running, ifa.finished, ifa.result_pass, ifa.cycle_count, ifa.idle_count);
        end
        checks++;
        if ({ifb.state_o, ifb.running, ifb.finished, ifb.result_pass, ifb.cycle_count, ifb.idle_count} !== 22'd0) begin
            errors++;
            $display("FAIL reset_b: got state=%0d run=%b fin=%b pass=%b cyc=%0d idle=%0d, expected all zero",
                     ifb.state_o, ifb.running, ifb.finished, ifb.result_pass, ifb.cycle_count, ifb.idle_count);
        end
        @(negedge ck) rst = 1'b0;
        ifa.heartbeat = 1'b1; ifa.done = 1'b1;
        repeat (3) @(negedge ck);
        ifa.heartbeat = 1'b0; ifa.done = 1'b0;
        checks++;
        if ({ifa.state_o, ifa.running, ifa.cycle_count} !== 12'd0) begin
            errors++;
            $display("FAIL idle_wait: got state=%0d run=%b cyc=%0d, expected 0 0 0",
                     ifa.state_o, ifa.running, ifa.cycle_count);
        end
    endtask

    task automatic test_done();
        do_reset();
        start_a();
        checks++;
        if ({ifa.state_o, ifa.running, ifa.cycle_count} !== {3'd1, 1'b1, 8'd0}) begin
            errors++;
            $display("FAIL run_entry: got state=%0d run=%b cyc=%0d, expected 1 1 0",
                     ifa.state_o, ifa.running, ifa.cycle_count);
        end
        for (int k = 1; k <= 9; k++) begin
            ifa.heartbeat = (k % 2 == 0);
            @(negedge ck);
        end
        checks++;
        if ({ifa.state_o, ifa.cycle_count, ifa.idle_count} !== {3'd1, 8'd9, 8'd1}) begin
            errors++;
            $display("FAIL done_pre: got state=%0d cyc=%0d idle=%0d, expected 1 9 1",
                     ifa.state_o, ifa.cycle_count, ifa.idle_count);
        end
        ifa.heartbeat = 1'b1; ifa.done = 1'b1; ifa.pass = 1'b1;
        @(negedge ck);
        ifa.heartbeat = 1'b0; ifa.done = 1'b0; ifa.pass = 1'b0;
        checks++;
        if ({ifa.state_o, ifa.running, ifa.finished, ifa.result_pass, ifa.cycle_count} !== {3'd2, 3'b011, 8'd9}) begin
            errors++;
            $display("FAIL done_pass: got state=%0d run=%b fin=%b pass=%b cyc=%0d, expected 2 0 1 1 9",
                     ifa.state_o, ifa.running, ifa.finished, ifa.result_pass, ifa.cycle_count);
        end
        ifa.done = 1'b1; ifa.pass = 1'b0; ifa.start = 1'b1;
        repeat (3) @(negedge ck);
        ifa.done = 1'b0; ifa.start = 1'b0;
        checks++;
        if ({ifa.state_o, ifa.result_pass, ifa.cycle_count, ifa.idle_count} !== {3'd2, 1'b1, 8'd9, 8'd1}) begin
            errors++;
            $display("FAIL done_sticky: got state=%0d pass=%b cyc=%0d idle=%0d, expected 2 1 9 1",
                     ifa.state_o, ifa.result_pass, ifa.cycle_count, ifa.idle_count);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        start_b();
        repeat (19) @(negedge ck);
        checks++;
        if ({ifb.state_o, ifb.cycle_count, ifb.idle_count} !== {3'd1, 8'd19, 8'd19}) begin
            errors++;
            $display("FAIL timeout_pre: got state=%0d cyc=%0d idle=%0d, expected 1 19 19",
                     ifb.state_o, ifb.cycle_count, ifb.idle_count);
        end
        @(negedge ck);
        checks++;
        if ({ifb.state_o, ifb.running, ifb.finished, ifb.result_pass, ifb.cycle_count} !== {3'd3, 3'b010, 8'd19}) begin
            errors++;
            $display("FAIL timeout: got state=%0d run=%b fin=%b pass=%b cyc=%0d, expected 3 0 1 0 19",
                     ifb.state_o, ifb.running, ifb.finished, ifb.result_pass, ifb.cycle_count);
        end
    endtask

    task automatic test_hang();
        do_reset();
        start_a();
        for (int k = 1; k <= 7; k++) begin
            ifa.heartbeat = (k <= 3);
            @(negedge ck);
        end
        ifa.heartbeat = 1'b0;
        checks++;
        if ({ifa.state_o, ifa.cycle_count, ifa.idle_count} !== {3'd1, 8'd7, 8'd4}) begin
            errors++;
            $display("FAIL hang_pre: got state=%0d cyc=%0d idle=%0d, expected 1 7 4",
                     ifa.state_o, ifa.cycle_count, ifa.idle_count);
        end
        @(negedge ck);
        checks++;
        if ({ifa.state_o, ifa.running, ifa.finished, ifa.result_pass, ifa.cycle_count, ifa.idle_count}
            !== {3'd4, 3'b010, 8'd7, 8'd4}) begin
            errors++;
            $display("FAIL hang: got state=%0d run=%b fin=%b pass=%b cyc=%0d idle=%0d, expected 4 0 1 0 7 4",
                     ifa.state_o, ifa.running, ifa.finished, ifa.result_pass, ifa.cycle_count, ifa.idle_count);
        end
        ifa.done = 1'b1; ifa.pass = 1'b1;
        @(negedge ck);
        ifa.done = 1'b0; ifa.pass = 1'b0;
        checks++;
        if ({ifa.state_o, ifa.result_pass} !== {3'd4, 1'b0}) begin
            errors++;
            $display("FAIL hang_late_done: got state=%0d pass=%b, expected 4 0", ifa.state_o, ifa.result_pass);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        start_a();
        for (int k = 1; k <= 19; k++) begin
            ifa.heartbeat = 1'b1;
            @(negedge ck);
        end
        ifa.done = 1'b1; ifa.pass = 1'b0;
        @(negedge ck);
        ifa.done = 1'b0; ifa.heartbeat = 1'b0;
        checks++;
        if ({ifa.state_o, ifa.finished, ifa.result_pass, ifa.cycle_count} !== {3'd2, 2'b10, 8'd19}) begin
            errors++;
            $display("FAIL done_at_limit: got state=%0d fin=%b pass=%b cyc=%0d, expected 2 1 0 19",
                     ifa.state_o, ifa.finished, ifa.result_pass, ifa.cycle_count);
        end

        do_reset();
        start_a();
        for (int k = 1; k <= 20; k++) begin
            ifa.heartbeat = 1'b1;
            @(negedge ck);
        end
        ifa.heartbeat = 1'b0;
        checks++;
        if ({ifa.state_o, ifa.result_pass, ifa.cycle_count, ifa.idle_count} !== {3'd3, 1'b0, 8'd19, 8'd0}) begin
            errors++;
            $display("FAIL hb_at_limit: got state=%0d pass=%b cyc=%0d idle=%0d, expected 3 0 19 0",
                     ifa.state_o, ifa.result_pass, ifa.cycle_count, ifa.idle_count);
        end

        do_reset();
        start_a();
        for (int k = 1; k <= 19; k++) begin
            ifa.heartbeat = (k <= 15);
            @(negedge ck);
        end
        ifa.heartbeat = 1'b0;
        checks++;
        if ({ifa.cycle_count, ifa.idle_count} !== {8'd19, 8'd4}) begin
            errors++;
            $display("FAIL both_pre: got cyc=%0d idle=%0d, expected 19 4", ifa.cycle_count, ifa.idle_count);
        end
        @(negedge ck);
        checks++;
        if (ifa.state_o !== 3'd3) begin
            errors++;
            $display("FAIL timeout_over_hang: got state=%0d, expected 3", ifa.state_o);
        end
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        start_a();
        for (int k = 1; k <= 6; k++) begin
            ifa.heartbeat = (k % 2 == 0);
            @(negedge ck);
        end
        checks++;
        if ({ifa.state_o, ifa.cycle_count} !== {3'd1, 8'd6}) begin
            errors++;
            $display("FAIL mid_pre: got state=%0d cyc=%0d, expected 1 6", ifa.state_o, ifa.cycle_count);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({ifa.state_o, ifa.running, ifa.finished, ifa.result_pass, ifa.cycle_count, ifa.idle_count} !== 22'd0) begin
            errors++;
            $display("FAIL async_reset: got state=%0d run=%b fin=%b pass=%b cyc=%0d idle=%0d, expected all zero",
                     ifa.state_o, ifa.running, ifa.finished, ifa.result_pass, ifa.cycle_count, ifa.idle_count);
        end
        @(negedge ck) rst = 1'b0;
        ifa.heartbeat = 1'b0;
        repeat (2) @(negedge ck);
        checks++;
        if (ifa.state_o !== 3'd0) begin
            errors++;
            $display("FAIL wait_idle: got state=%0d, expected 0", ifa.state_o);
        end
        start_a();
        checks++;
        if ({ifa.state_o, ifa.cycle_count} !== {3'd1, 8'd0}) begin
            errors++;
            $display("FAIL restart: got state=%0d cyc=%0d, expected 1 0", ifa.state_o, ifa.cycle_count);
        end
        ifa.heartbeat = 1'b1;
        @(negedge ck);
        ifa.heartbeat = 1'b0;
        checks++;
        if (ifa.cycle_count !== 8'd1) begin
            errors++;
            $display("FAIL restart_count: got cyc=%0d, expected 1", ifa.cycle_count);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        start_a();
        for (int k = 1; k <= 2; k++) begin
            ifa.heartbeat = 1'b1;
            @(negedge ck);
        end
        ifa.start = 1'b1; ifa.heartbeat = 1'b1;
        @(negedge ck);
        ifa.start = 1'b0;
        checks++;
        if ({ifa.state_o, ifa.cycle_count, ifa.idle_count} !== {3'd1, 8'd3, 8'd0}) begin
            errors++;
            $display("FAIL second_start: got state=%0d cyc=%0d idle=%0d, expected 1 3 0",
                     ifa.state_o, ifa.cycle_count, ifa.idle_count);
        end
        for (int k = 4; k <= 5; k++) begin
            ifa.heartbeat = 1'b0;
            @(negedge ck);
        end
        checks++;
        if ({ifa.cycle_count, ifa.idle_count} !== {8'd5, 8'd2}) begin
            errors++;
            $display("FAIL continue_count: got cyc=%0d idle=%0d, expected 5 2", ifa.cycle_count, ifa.idle_count);
        end
    endtask

    initial begin
        test_reset();
        test_done();
        test_timeout();
        test_hang();
        test_simultaneous();
        test_reset_mid_run();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
